hyper_mvblck_frdram: RTL and testbench
======================================

HYPER_MVBLCK_FRDRAM -- requirements
Module: hyper_mvblck_frdram

Interface
REQ-001 SHALL have ports, in order:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- LSAB_0_FULL..LSAB_3_FULL  in  1 each  section n has fewer than 4 free slots.
- LSAB_WRITE  out  1  write strobe, one word into LSAB.
- LSAB_SECTION  out  2  target section.
- LSAB_INT  out  1  block-end interrupt marker.
- LSAB_ANCILL  out  25  ancillary word to LSAB.
- START_ADDRESS  in  9  DRAM column address of first word.
- COUNT_REQ  in  6  words requested.
- SECTION  in  2  LSAB section.
- DRAM_SEL  in  2  DRAM chip select code.
- ISSUE  in  1  start pulse.
- IRQ_IN  in  1  interrupt flag for block.
- ANCILL_IN  in  25  ancillary data for block.
- COUNT_SENT  out  6  words written to LSAB by last job.
- WORKING  out  1  busy, delayed.
- ABRUPT_STOP  out  1  last job ended early on LSAB full.
- MCU_COLL_ADDRESS  out  9  even-aligned pair address.
- MCU_REQUEST_ACCESS  out  2  request, nonzero for one cycle per pair.
- MCU_WORD_VALID  in  1  one read word from MCU lands in LSAB write port this cycle.

Function
REQ-002 SHALL have FSM states IDLE, REQ, DRAIN, DONE.
REQ-003 In IDLE, ISSUE=1 SHALL latch START_ADDRESS, COUNT_REQ, SECTION, DRAM_SEL, IRQ_IN, ANCILL_IN and go to REQ; LSAB_SECTION updates in the same cycle.
REQ-004 ISSUE outside IDLE SHALL be ignored.
REQ-005 Words fetched SHALL be need = COUNT_REQ + START_ADDRESS[0] (7 bits); the first returned word SHALL be discarded, not written, when START_ADDRESS[0]=1.
REQ-006 In REQ, one pair request SHALL be issued every second cycle, first in the cycle after entry.
REQ-007 Each request drives MCU_COLL_ADDRESS={addr[8:1],1'b0} and MCU_REQUEST_ACCESS=DRAM_SEL for one cycle; addr advances by 2, wrapping modulo 512.
REQ-008 MCU_REQUEST_ACCESS SHALL be 0 in all other cycles.
REQ-009 A request SHALL not issue if the selected LSAB_n_FULL=1 in the issue cycle; the job then stops issuing, ABRUPT flag set, go to DRAIN.
REQ-010 When issued words >= need, SHALL go to DRAIN.
REQ-011 In DRAIN, each MCU_WORD_VALID SHALL increment received count.
REQ-012 LSAB_WRITE=MCU_WORD_VALID in the same cycle unless the word is the odd-start discard or written count already equals COUNT_REQ (odd tail).
REQ-013 DRAIN->DONE when received == issued words.
REQ-014 MCU_WORD_VALID also accepted during REQ, counted identically.
REQ-015 In DONE (one cycle), SHALL set COUNT_SENT=written count and ABRUPT_STOP=flag, then go to IDLE.
REQ-016 COUNT_REQ=0 SHALL issue no request and reach DONE in 2 cycles with COUNT_SENT=0, ABRUPT_STOP=0.
REQ-017 WORKING SHALL equal (state != IDLE) delayed by exactly two cycles.
REQ-018 MCU_WORD_VALID in IDLE SHALL be ignored; no LSAB_WRITE.
REQ-019 COUNT_SENT, ABRUPT_STOP SHALL hold until next DONE.

Reset
REQ-020 RST=1 at any cycle SHALL force IDLE, abandon the job, zero all counters and all outputs (LSAB_SECTION=0, MCU_COLL_ADDRESS=0, COUNT_SENT=0, WORKING=0, LSAB_ANCILL=0) the next cycle.
REQ-021 Words returning after reset SHALL be ignored per REQ-018.

Configuration
REQ-022 Macro HYPER_MVBLCK_FRDRAM_INT_EN: defined -> on the final LSAB_WRITE of a non-abrupt job, LSAB_INT=latched IRQ_IN and LSAB_ANCILL=latched ANCILL_IN for that cycle, else 0.
REQ-023 Undefined -> LSAB_INT and LSAB_ANCILL tied 0, ports retained.

Structure
REQ-024 Package hyper_mvblck_pkg SHALL hold the FSM state typedef, address/count width constants and pair size 2.
REQ-025 One sub-module, hyper_lsab_full_sel (4:1 full select by section), is natural; the rest stays flat.

Verification
REQ-026 ISSUE, addr 0x010, count 8, FULL=0 -> 4 requests at 0x010/012/014/016 on alternate cycles, 8 LSAB_WRITE, COUNT_SENT=8, ABRUPT_STOP=0.
REQ-027 Addr 0x005, count 3 -> requests 0x004, 0x006; first word discarded, 3 writes, COUNT_SENT=3.
REQ-028 Count 8, FULL=1 from the third request slot -> 2 requests, 4 writes, COUNT_SENT=4, ABRUPT_STOP=1, LSAB_INT=0.
REQ-029 Addr 0x1FE, count 4 -> requests 0x1FE then 0x000.
REQ-030 RST mid-DRAIN with 2 words outstanding -> IDLE, no writes for the late valids, COUNT_SENT=0; new ISSUE works.
REQ-031 With INT_EN, IRQ_IN=1, ANCILL_IN=0x1ABCDEF, count 2 -> LSAB_INT=1, LSAB_ANCILL=0x1ABCDEF on the second write only; WORKING lags busy by 2 cycles.

Source files
------------

// File: rtl/hyper_mvblck_pkg.sv
// Shared types and constants for the DRAM-to-LSAB block mover.
//   state_t : mover FSM states
//   ADDR_W  : DRAM column address width
//   CNT_W   : requested/sent word count width
//   NEED_W  : fetched word count width (count plus odd-start word)
//   ANC_W   : ancillary word width
//   PAIR    : words returned per MCU request
package hyper_mvblck_pkg;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 6;
    localparam int NEED_W = 7;
    localparam int ANC_W  = 25;
    localparam int PAIR   = 2;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
endpackage

// File: rtl/hyper_lsab_full_sel.sv
// Selects the "almost full" flag of the LSAB section targeted by the job.
//   i_full : per-section full flags (bit n = section n)
//   i_sel  : section index
//   o_full : full flag of the selected section
module hyper_lsab_full_sel (
    input  logic [3:0] i_full,
    input  logic [1:0] i_sel,
    output logic       o_full
);
    assign o_full = i_full[i_sel];
endmodule

// File: rtl/hyper_mvblck_frdram.sv
// Block mover: fetches a run of words from DRAM through the MCU in pairs and
// writes them into one section of the LSAB.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   LSAB_n_FULL              section n has fewer than 4 free slots
//   LSAB_WRITE/SECTION       LSAB write strobe and target section
//   LSAB_INT/ANCILL          block-end marker and ancillary word
//   START_ADDRESS..ANCILL_IN job parameters, latched on ISSUE in IDLE
//   COUNT_SENT, ABRUPT_STOP  result of the last job, held until next job ends
//   WORKING                  busy, delayed two cycles
//   MCU_COLL_ADDRESS/REQUEST_ACCESS  pair request to the MCU
//   MCU_WORD_VALID           one read word arrives this cycle
// Optional feature: define HYPER_MVBLCK_FRDRAM_INT_EN to flag the final write
// of a complete job with the latched IRQ and ancillary word.
module hyper_mvblck_frdram
    import hyper_mvblck_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              LSAB_0_FULL,
    input  logic              LSAB_1_FULL,
    input  logic              LSAB_2_FULL,
    input  logic              LSAB_3_FULL,
    output logic              LSAB_WRITE,
    output logic [1:0]        LSAB_SECTION,
    output logic              LSAB_INT,
    output logic [ANC_W-1:0]  LSAB_ANCILL,
    input  logic [ADDR_W-1:0] START_ADDRESS,
    input  logic [CNT_W-1:0]  COUNT_REQ,
    input  logic [1:0]        SECTION,
    input  logic [1:0]        DRAM_SEL,
    input  logic              ISSUE,
    input  logic              IRQ_IN,
    input  logic [ANC_W-1:0]  ANCILL_IN,
    output logic [CNT_W-1:0]  COUNT_SENT,
    output logic              WORKING,
    output logic              ABRUPT_STOP,
    output logic [ADDR_W-1:0] MCU_COLL_ADDRESS,
    output logic [1:0]        MCU_REQUEST_ACCESS,
    input  logic              MCU_WORD_VALID
);
    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_sect;
    logic [1:0]          r_dsel;
    logic [NEED_W-1:0]   r_need;
    logic [NEED_W-1:0]   r_issued;
    logic [NEED_W-1:0]   r_recv;
    logic [CNT_W-1:0]    r_written;
    logic                r_gap;      // odd REQ cycles are idle gaps between pair requests
    logic                r_abrupt;
    logic [CNT_W-1:0]    r_cnt_sent;
    logic                r_abrupt_stop;
    logic [1:0]          r_wk;

    logic                w_full, w_slot, w_req, w_active, w_accept, w_discard, w_write;
    logic [NEED_W-1:0]   w_recv_nxt, w_issued_nxt;

    hyper_lsab_full_sel u_full_sel (
        .i_full ({LSAB_3_FULL, LSAB_2_FULL, LSAB_1_FULL, LSAB_0_FULL}),
        .i_sel  (r_sect),
        .o_full (w_full)
    );

    assign w_active     = (r_state == REQ) || (r_state == DRAIN);
    assign w_slot       = (r_state == REQ) && !r_gap && (r_issued < r_need);
    assign w_req        = w_slot && !w_full;
    assign w_accept     = MCU_WORD_VALID && w_active;
    // Odd start: the pair's even word precedes the requested one and is dropped.
    assign w_discard    = r_addr[0] && (r_recv == '0);
    // Odd tail: the pair's last word lies beyond the requested run.
    assign w_write      = w_accept && !w_discard && (r_written != r_cnt);
    assign w_recv_nxt   = r_recv + {{(NEED_W-1){1'b0}}, w_accept};
    assign w_issued_nxt = r_issued + NEED_W'(PAIR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (ISSUE) w_state_nxt = REQ;
            REQ: begin
                if (r_issued >= r_need)                 w_state_nxt = DRAIN;
                else if (w_slot && w_full)              w_state_nxt = DRAIN;
                else if (w_req && w_issued_nxt >= r_need) w_state_nxt = DRAIN;
            end
            DRAIN: if (w_recv_nxt == r_issued) w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_cnt         <= '0;
            r_sect        <= '0;
            r_dsel        <= '0;
            r_need        <= '0;
            r_issued      <= '0;
            r_recv        <= '0;
            r_written     <= '0;
            r_gap         <= 1'b0;
            r_abrupt      <= 1'b0;
            r_cnt_sent    <= '0;
            r_abrupt_stop <= 1'b0;
            r_wk          <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wk    <= {r_wk[0], r_state != IDLE};
            if (r_state == IDLE && ISSUE) begin
                r_addr    <= START_ADDRESS;
                r_cnt     <= COUNT_REQ;
                r_sect    <= SECTION;
                r_dsel    <= DRAM_SEL;
                // An empty job fetches nothing, even from an odd start.
                r_need    <= (COUNT_REQ == '0) ? '0
                             : {1'b0, COUNT_REQ} + {{(NEED_W-1){1'b0}}, START_ADDRESS[0]};
                r_issued  <= '0;
                r_recv    <= '0;
                r_written <= '0;
                r_gap     <= 1'b0;
                r_abrupt  <= 1'b0;
            end
            if (r_state == REQ) begin
                r_gap <= ~r_gap;
                if (w_req) begin
                    r_issued <= w_issued_nxt;
                    r_addr   <= r_addr + ADDR_W'(PAIR);
                end
                if (w_slot && w_full) r_abrupt <= 1'b1;
            end
            if (w_accept) r_recv    <= w_recv_nxt;
            if (w_write)  r_written <= r_written + 1'b1;
            if (r_state == DONE) begin
                r_cnt_sent    <= r_written;
                r_abrupt_stop <= r_abrupt;
            end
        end
    end

    assign LSAB_WRITE         = w_write;
    assign LSAB_SECTION       = (r_state == IDLE && ISSUE && !RST) ? SECTION : r_sect;
    assign MCU_COLL_ADDRESS   = w_req ? {r_addr[ADDR_W-1:1], 1'b0} : '0;
    assign MCU_REQUEST_ACCESS = w_req ? r_dsel : 2'b00;
    assign COUNT_SENT         = r_cnt_sent;
    assign ABRUPT_STOP        = r_abrupt_stop;
    assign WORKING            = r_wk[1];

`ifdef HYPER_MVBLCK_FRDRAM_INT_EN
    logic              r_irq;
    logic [ANC_W-1:0]  r_anc;
    logic              w_last_wr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_irq <= 1'b0;
            r_anc <= '0;
        end else if (r_state == IDLE && ISSUE) begin
            r_irq <= IRQ_IN;
            r_anc <= ANCILL_IN;
        end
    end

    assign w_last_wr   = w_write && !r_abrupt && ({1'b0, r_written} + 1'b1 == {1'b0, r_cnt});
    assign LSAB_INT    = w_last_wr && r_irq;
    assign LSAB_ANCILL = w_last_wr ? r_anc : '0;
`else
    logic w_unused_int;
    assign w_unused_int = ^{IRQ_IN, ANCILL_IN};
    assign LSAB_INT     = 1'b0;
    assign LSAB_ANCILL  = '0;
`endif
endmodule

// File: tb/tb_hyper_mvblck_frdram.sv
module tb_hyper_mvblck_frdram;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  full = '0;
    logic        LSAB_WRITE, LSAB_INT, WORKING, ABRUPT_STOP;
    logic [1:0]  LSAB_SECTION, MCU_REQUEST_ACCESS;
    logic [24:0] LSAB_ANCILL;
    logic [8:0]  START_ADDRESS = '0, MCU_COLL_ADDRESS;
    logic [5:0]  COUNT_REQ = '0, COUNT_SENT;
    logic [1:0]  SECTION = '0, DRAM_SEL = '0;
    logic        ISSUE = 1'b0, IRQ_IN = 1'b0, MCU_WORD_VALID = 1'b0;
    logic [24:0] ANCILL_IN = '0;

    hyper_mvblck_frdram dut (
        .CLK(CLK), .RST(RST),
        .LSAB_0_FULL(full[0]), .LSAB_1_FULL(full[1]), .LSAB_2_FULL(full[2]), .LSAB_3_FULL(full[3]),
        .LSAB_WRITE(LSAB_WRITE), .LSAB_SECTION(LSAB_SECTION), .LSAB_INT(LSAB_INT), .LSAB_ANCILL(LSAB_ANCILL),
        .START_ADDRESS(START_ADDRESS), .COUNT_REQ(COUNT_REQ), .SECTION(SECTION), .DRAM_SEL(DRAM_SEL),
        .ISSUE(ISSUE), .IRQ_IN(IRQ_IN), .ANCILL_IN(ANCILL_IN),
        .COUNT_SENT(COUNT_SENT), .WORKING(WORKING), .ABRUPT_STOP(ABRUPT_STOP),
        .MCU_COLL_ADDRESS(MCU_COLL_ADDRESS), .MCU_REQUEST_ACCESS(MCU_REQUEST_ACCESS),
        .MCU_WORD_VALID(MCU_WORD_VALID)
    );

    always #5 CLK = ~CLK;

    int nchk = 0, nerr = 0;
    int n_req, n_wr, wk_rise, wk_last, int_hits, int_at, anc_hits, wr_after_rst, bad_sel, bad_sect, done_ok;
    logic [8:0]  req_addr [8];
    int          req_win  [8];
    logic [24:0] anc_val;
    int ret_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One job: window 0 drives ISSUE; window k is the cycle after the k-th edge.
    // The MCU model answers a request seen in window k with words in k+2, k+3.
    task automatic run_job(input logic [8:0] a, input logic [5:0] c, input logic [1:0] s,
                           input logic [1:0] d, input int full_after, input logic irq,
                           input logic [24:0] anc, input int ign_win, input int rst_win);
        int cyc;
        n_req = 0; n_wr = 0; wk_rise = -1; wk_last = -1; int_hits = 0; int_at = -1;
        anc_hits = 0; anc_val = '0; wr_after_rst = 0; bad_sel = 0; bad_sect = 0; done_ok = 0;
        ret_q.delete();
        for (int i = 0; i < 8; i++) begin req_addr[i] = '0; req_win[i] = -1; end
        @(negedge CLK);
        for (cyc = 0; cyc < 300; cyc++) begin
            ISSUE = (cyc == 0) || (cyc == ign_win);
            if (cyc == 0) begin
                START_ADDRESS = a; COUNT_REQ = c; SECTION = s; DRAM_SEL = d; IRQ_IN = irq; ANCILL_IN = anc;
            end else if (cyc == ign_win) begin
                START_ADDRESS = 9'h100; COUNT_REQ = 6'd1; SECTION = ~s; DRAM_SEL = ~d;
            end
            RST = (cyc == rst_win);
            MCU_WORD_VALID = (ret_q.size() > 0) && (ret_q[0] == cyc);
            if (MCU_WORD_VALID) void'(ret_q.pop_front());
            if (full_after >= 0 && n_req >= full_after) full[s] = 1'b1;
            #1;
            if (cyc == 0 || cyc == ign_win) chk("section_live", LSAB_SECTION, s);
            if (rst_win >= 0 && cyc == rst_win + 1) begin
                chk("rst_working", WORKING, 0);
                chk("rst_count_sent", COUNT_SENT, 0);
                chk("rst_abrupt", ABRUPT_STOP, 0);
                chk("rst_section", LSAB_SECTION, 0);
                chk("rst_coll_addr", MCU_COLL_ADDRESS, 0);
            end
            if (MCU_REQUEST_ACCESS != 2'b00) begin
                if (n_req < 8) begin req_addr[n_req] = MCU_COLL_ADDRESS; req_win[n_req] = cyc; end
                if (MCU_REQUEST_ACCESS != d) bad_sel++;
                n_req++;
                ret_q.push_back(cyc + 2);
                ret_q.push_back(cyc + 3);
            end
            if (LSAB_WRITE) begin
                n_wr++;
                if (LSAB_SECTION != s) bad_sect++;
                if (rst_win >= 0 && cyc > rst_win) wr_after_rst++;
            end
            if (LSAB_INT) begin int_hits++; int_at = n_wr; end
            if (LSAB_ANCILL != '0) begin anc_hits++; anc_val = LSAB_ANCILL; end
            if (WORKING) begin if (wk_rise < 0) wk_rise = cyc; wk_last = cyc; end
            @(negedge CLK);
            if (cyc > 0 && wk_rise >= 0 && !WORKING && ret_q.size() == 0) begin done_ok = 1; break; end
        end
        ISSUE = 1'b0; RST = 1'b0; MCU_WORD_VALID = 1'b0; full = '0;
        chk("job_terminates", done_ok, 1);
        chk("req_code", bad_sel, 0);
        chk("write_section", bad_sect, 0);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_working", WORKING, 0);
        chk("reset_count_sent", COUNT_SENT, 0);
        chk("reset_abrupt", ABRUPT_STOP, 0);
        chk("reset_req", MCU_REQUEST_ACCESS, 0);
        chk("reset_coll_addr", MCU_COLL_ADDRESS, 0);
        chk("reset_ancill", LSAB_ANCILL, 0);
        @(negedge CLK); RST = 1'b0;

        // Stray word in IDLE
        @(negedge CLK); MCU_WORD_VALID = 1'b1; #1;
        chk("idle_valid_no_write", LSAB_WRITE, 0);
        @(negedge CLK); MCU_WORD_VALID = 1'b0;

        // Aligned 8-word job, with a stray ISSUE in REQ
        run_job(9'h010, 6'd8, 2'd1, 2'd1, -1, 1'b0, 25'h0, 2, -1);
        chk("j1_nreq", n_req, 4);
        chk("j1_a0", req_addr[0], 9'h010);
        chk("j1_a1", req_addr[1], 9'h012);
        chk("j1_a2", req_addr[2], 9'h014);
        chk("j1_a3", req_addr[3], 9'h016);
        chk("j1_w0", req_win[0], 1);
        chk("j1_w1", req_win[1], 3);
        chk("j1_w3", req_win[3], 7);
        chk("j1_nwr", n_wr, 8);
        chk("j1_count_sent", COUNT_SENT, 8);
        chk("j1_abrupt", ABRUPT_STOP, 0);
        chk("j1_wk_rise", wk_rise, 3);
        chk("j1_wk_last", wk_last, 13);

        // Odd start: first word discarded
        run_job(9'h005, 6'd3, 2'd0, 2'd2, -1, 1'b0, 25'h0, -1, -1);
        chk("j2_nreq", n_req, 2);
        chk("j2_a0", req_addr[0], 9'h004);
        chk("j2_a1", req_addr[1], 9'h006);
        chk("j2_nwr", n_wr, 3);
        chk("j2_count_sent", COUNT_SENT, 3);

        // Address wrap
        run_job(9'h1FE, 6'd4, 2'd3, 2'd3, -1, 1'b0, 25'h0, -1, -1);
        chk("j3_nreq", n_req, 2);
        chk("j3_a0", req_addr[0], 9'h1FE);
        chk("j3_a1", req_addr[1], 9'h000);
        chk("j3_count_sent", COUNT_SENT, 4);

        // Section full from the third request slot
        run_job(9'h020, 6'd8, 2'd2, 2'd1, 2, 1'b1, 25'h155, -1, -1);
        chk("j4_nreq", n_req, 2);
        chk("j4_nwr", n_wr, 4);
        chk("j4_count_sent", COUNT_SENT, 4);
        chk("j4_abrupt", ABRUPT_STOP, 1);
        chk("j4_int", int_hits, 0);
        chk("j4_ancill", anc_hits, 0);

        // Reset with two words outstanding
        run_job(9'h040, 6'd4, 2'd2, 2'd2, -1, 1'b0, 25'h0, -1, 4);
        chk("j5_nwr", n_wr, 2);
        chk("j5_late_writes", wr_after_rst, 0);
        chk("j5_count_sent", COUNT_SENT, 0);

        // Empty job from an odd start
        run_job(9'h003, 6'd0, 2'd1, 2'd1, -1, 1'b0, 25'h0, -1, -1);
        chk("j6_nreq", n_req, 0);
        chk("j6_nwr", n_wr, 0);
        chk("j6_count_sent", COUNT_SENT, 0);
        chk("j6_abrupt", ABRUPT_STOP, 0);
        chk("j6_wk_rise", wk_rise, 3);
        chk("j6_wk_last", wk_last, 5);

        // Two-word job with interrupt marker
        run_job(9'h0A0, 6'd2, 2'd1, 2'd1, -1, 1'b1, 25'h1ABCDEF, -1, -1);
        chk("j7_nreq", n_req, 1);
        chk("j7_nwr", n_wr, 2);
        chk("j7_count_sent", COUNT_SENT, 2);
        chk("j7_wk_rise", wk_rise, 3);
        chk("j7_wk_last", wk_last, 7);
`ifdef HYPER_MVBLCK_FRDRAM_INT_EN
        chk("j7_int_hits", int_hits, 1);
        chk("j7_int_at", int_at, 2);
        chk("j7_anc_hits", anc_hits, 1);
        chk("j7_anc_val", anc_val, 25'h1ABCDEF);
`else
        chk("j7_int_hits", int_hits, 0);
        chk("j7_anc_hits", anc_hits, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
